// File: rtl/fade_pkg.sv
`default_nettype none
// ============================================================================
// Module  : fade_pkg
// Purpose : Shared state encoding, widths and brightness curve for the
//           fade ramp controller.
// Rev     : 1.0  initial release
// ============================================================================
package fade_pkg;

  // State encoding is visible on the State port, so the values are fixed.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RISE = 2'd1,
    ST_HOLD = 2'd2,
    ST_FALL = 2'd3
  } fade_state_t;

  localparam int LUT_DEPTH = 32;
  localparam int IDX_W     = 5;
  localparam int DUTY_W    = 8;
  localparam int RATE_W    = 4;

  localparam logic [IDX_W-1:0] IDX_MIN = 5'd0;
  localparam logic [IDX_W-1:0] IDX_MAX = 5'd31;

  // Roughly quadratic (perceptual) brightness curve, strictly increasing so
  // every step produces a visible duty change. Entry 0 sits in the low byte.
  localparam logic [LUT_DEPTH*DUTY_W-1:0] LUT_DATA = {
    8'd255, 8'd239, 8'd223, 8'd208, 8'd193, 8'd179, 8'd166, 8'd153,
    8'd140, 8'd128, 8'd117, 8'd106, 8'd96,  8'd86,  8'd77,  8'd68,
    8'd60,  8'd52,  8'd45,  8'd38,  8'd32,  8'd27,  8'd21,  8'd17,
    8'd13,  8'd10,  8'd7,   8'd4,   8'd3,   8'd2,   8'd1,   8'd0
  };

  // Extract one curve entry by index.
  function automatic logic [DUTY_W-1:0] lut_entry(input logic [IDX_W-1:0] idx);
    return LUT_DATA[int'(idx)*DUTY_W +: DUTY_W];
  endfunction

endpackage
`default_nettype wire

// File: rtl/fade_lut.sv
`default_nettype none
// ============================================================================
// Module  : fade_lut
// Purpose : Combinational 32-entry brightness lookup (5-bit address, 8-bit
//           duty).
// Rev     : 1.0  initial release
// ============================================================================
module fade_lut
  import fade_pkg::*;
(
  input  logic [IDX_W-1:0]  addr,
  output logic [DUTY_W-1:0] data
);

  // Pure table read; no state.
  always_comb begin
    data = lut_entry(addr);
  end

endmodule
`default_nettype wire

// File: rtl/fade_ramp_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : fade_ramp_ctrl
// Purpose : LED fade sequencer. Ramps a PWM duty up the brightness curve,
//           holds at full brightness, ramps back down, then loops or stops.
//           Duty only changes on the PWM wrap (Q == 255) so each new value
//           is used for a whole PWM period starting at Q == 0.
// Rev     : 1.0  initial release
// ============================================================================
module fade_ramp_ctrl
  import fade_pkg::*;
#(
  parameter int HOLD_PERIODS = 64,
  parameter bit LOOP_EN      = 1'b1
) (
  input  logic              Clock,
  input  logic              Resetn,
  input  logic              Start,
  input  logic              Stop,
  input  logic [RATE_W-1:0] Rate,
  input  logic [DUTY_W-1:0] Q,
  output logic [DUTY_W-1:0] Duty,
  output logic [1:0]        State,
  output logic              Busy,
  output logic              Done
);

  // A zero hold length is treated as one period so the FSM cannot stall.
  localparam int HOLD_N = (HOLD_PERIODS < 1) ? 1 : HOLD_PERIODS;
  localparam int HOLD_W = (HOLD_N > 1) ? $clog2(HOLD_N) : 1;
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_N - 1);

  fade_state_t         state;
  logic [IDX_W-1:0]    idx;
  logic [RATE_W-1:0]   per_cnt;
  // The 4-bit period counter cannot reach large hold lengths, so the hold
  // phase keeps its own wrap counter sized from HOLD_PERIODS.
  logic [HOLD_W-1:0]   hold_cnt;
  logic [DUTY_W-1:0]   duty;
  logic                busy;
  logic                done;

  logic                wrap;
  logic [RATE_W-1:0]   div;
  logic [RATE_W:0]     per_next;
  logic                step;
  logic [IDX_W-1:0]    idx_up;
  logic [IDX_W-1:0]    idx_dn;
  logic [IDX_W-1:0]    lut_addr;
  logic [DUTY_W-1:0]   lut_data;

  assign wrap     = (Q == 8'd255);
  assign div      = (Rate == '0) ? 4'd1 : Rate;
  assign per_next = {1'b0, per_cnt} + 5'd1;
  // ">=" rather than "==" so that lowering Rate below the current count
  // still steps on the very next wrap instead of running the counter away.
  assign step     = wrap && (per_next >= {1'b0, div});

  // Saturating neighbours keep the index inside the table at both ends.
  assign idx_up = (idx == IDX_MAX) ? idx : idx + 5'd1;
  assign idx_dn = (idx == IDX_MIN) ? idx : idx - 5'd1;

  // Look up the value the next step will load, depending on ramp direction.
  always_comb begin
    lut_addr = idx;
    case (state)
      ST_IDLE: lut_addr = IDX_MIN;
      ST_RISE: lut_addr = idx_up;
      ST_FALL: lut_addr = idx_dn;
      default: lut_addr = idx;
    endcase
  end

  fade_lut u_lut (
    .addr (lut_addr),
    .data (lut_data)
  );

  // Sequencer FSM with its index/period counters and registered outputs.
  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      state    <= ST_IDLE;
      idx      <= IDX_MIN;
      per_cnt  <= '0;
      hold_cnt <= '0;
      duty     <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else if (Stop) begin
      // Abort is immediate and silent: no wrap alignment, no Done.
      state    <= ST_IDLE;
      idx      <= IDX_MIN;
      per_cnt  <= '0;
      hold_cnt <= '0;
      duty     <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (Start) begin
            state    <= ST_RISE;
            idx      <= IDX_MIN;
            per_cnt  <= '0;
            hold_cnt <= '0;
            duty     <= lut_data;
            busy     <= 1'b1;
          end
        end

        ST_RISE: begin
          if (wrap) begin
            if (step) begin
              per_cnt <= '0;
              idx     <= idx_up;
              duty    <= lut_data;
              if (idx_up == IDX_MAX) begin
                state    <= ST_HOLD;
                hold_cnt <= '0;
              end
            end else begin
              per_cnt <= per_next[RATE_W-1:0];
            end
          end
        end

        ST_HOLD: begin
          if (wrap) begin
            if (hold_cnt == HOLD_LAST) begin
              // Duty stays at full brightness; the first fall step comes
              // a full Rate interval later.
              state    <= ST_FALL;
              per_cnt  <= '0;
              hold_cnt <= '0;
            end else begin
              hold_cnt <= hold_cnt + HOLD_W'(1);
            end
          end
        end

        ST_FALL: begin
          if (wrap) begin
            if (step) begin
              per_cnt <= '0;
              idx     <= idx_dn;
              duty    <= lut_data;
              if (idx_dn == IDX_MIN) begin
                if (LOOP_EN) begin
                  state <= ST_RISE;
                end else begin
                  state <= ST_IDLE;
                  busy  <= 1'b0;
                  done  <= 1'b1;
                end
              end
            end else begin
              per_cnt <= per_next[RATE_W-1:0];
            end
          end
        end

        default: begin
          state <= ST_IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

  assign Duty  = duty;
  assign State = state;
  assign Busy  = busy;
  assign Done  = done;

endmodule
`default_nettype wire

// File: tb/tb_fade_ramp_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : tb_fade_ramp_ctrl
// Purpose : Self-checking bench for fade_ramp_ctrl. Two instances (one-shot
//           and looping) share stimulus; a per-edge behavioural model is
//           compared on every falling edge, plus directed literal checks.
// Rev     : 1.0  initial release
// ============================================================================
module tb_fade_ramp_ctrl;

  localparam int HOLD_P = 2;

  logic       Clock = 1'b0;
  logic       Resetn;
  logic       Start;
  logic       Stop;
  logic [3:0] Rate;
  logic [7:0] Q;

  logic [7:0] duty0, duty1;
  logic [1:0] st0, st1;
  logic       busy0, busy1, done0, done1;

  int total = 0;
  int bad   = 0;

  // Expected brightness curve (strictly increasing, 0 .. 255).
  int tbl [32] = '{0, 1, 2, 3, 4, 7, 10, 13, 17, 21, 27, 32, 38, 45, 52, 60,
                   68, 77, 86, 96, 106, 117, 128, 140, 153, 166, 179, 193,
                   208, 223, 239, 255};

  always #5 Clock = ~Clock;

  fade_ramp_ctrl #(.HOLD_PERIODS(HOLD_P), .LOOP_EN(1'b0)) dut_once (
    .Clock(Clock), .Resetn(Resetn), .Start(Start), .Stop(Stop),
    .Rate(Rate), .Q(Q), .Duty(duty0), .State(st0), .Busy(busy0), .Done(done0)
  );

  fade_ramp_ctrl #(.HOLD_PERIODS(HOLD_P), .LOOP_EN(1'b1)) dut_loop (
    .Clock(Clock), .Resetn(Resetn), .Start(Start), .Stop(Stop),
    .Rate(Rate), .Q(Q), .Duty(duty1), .State(st1), .Busy(busy1), .Done(done1)
  );

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // mode: 0 idle, 1 rising, 2 holding, 3 falling; lvl = curve position.
  int m_mode [2];
  int m_lvl  [2];
  int m_cnt  [2];
  int m_duty [2];
  int m_done [2];

  task automatic model_edge(input int i, input bit loop);
    int div;
    div = (Rate == 4'd0) ? 1 : int'(Rate);
    m_done[i] = 0;
    if (Stop) begin
      m_mode[i] = 0; m_lvl[i] = 0; m_cnt[i] = 0; m_duty[i] = 0;
    end else if (m_mode[i] == 0) begin
      if (Start) begin
        m_mode[i] = 1; m_lvl[i] = 0; m_cnt[i] = 0; m_duty[i] = tbl[0];
      end
    end else if (Q == 8'd255) begin
      m_cnt[i] = m_cnt[i] + 1;
      if (m_mode[i] == 2) begin
        if (m_cnt[i] >= HOLD_P) begin
          m_mode[i] = 3; m_cnt[i] = 0;
        end
      end else if (m_cnt[i] >= div) begin
        m_cnt[i] = 0;
        m_lvl[i] = m_lvl[i] + ((m_mode[i] == 1) ? 1 : -1);
        m_duty[i] = tbl[m_lvl[i]];
        if (m_mode[i] == 1 && m_lvl[i] == 31) begin
          m_mode[i] = 2;
        end else if (m_mode[i] == 3 && m_lvl[i] == 0) begin
          if (loop) m_mode[i] = 1;
          else begin
            m_mode[i] = 0; m_done[i] = 1;
          end
        end
      end
    end
  endtask

  always @(posedge Clock or negedge Resetn) begin
    for (int i = 0; i < 2; i++) begin
      if (!Resetn) begin
        m_mode[i] = 0; m_lvl[i] = 0; m_cnt[i] = 0; m_duty[i] = 0; m_done[i] = 0;
      end else begin
        model_edge(i, i == 1);
      end
    end
  end

  function automatic int model_word(input int i);
    return (m_duty[i] << 4) | (m_mode[i] << 2) | ((m_mode[i] != 0) ? 2 : 0) | m_done[i];
  endfunction

  // ---------------- per-cycle compare ----------------
  logic [7:0] pq    = 8'd0;
  logic       pstop = 1'b0;
  logic       prst  = 1'b0;
  logic [7:0] pd0   = 8'd0;
  logic [7:0] pd1   = 8'd0;

  always @(negedge Clock) begin
    check("dut_once {duty,state,busy,done}", int'({duty0, st0, busy0, done0}), model_word(0));
    check("dut_loop {duty,state,busy,done}", int'({duty1, st1, busy1, done1}), model_word(1));
    if (Resetn && prst && !pstop && duty0 != pd0) check("dut_once duty change only after Q=255", int'(pq), 255);
    if (Resetn && prst && !pstop && duty1 != pd1) check("dut_loop duty change only after Q=255", int'(pq), 255);
    pd0 = duty0; pd1 = duty1; pq = Q; pstop = Stop; prst = Resetn;
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge Clock);
    #1;
    Q = Q + 8'd1;
  endtask

  int trace_a [2048];
  int trace_b [2048];

  initial begin
    int c, k, lastc, n, mism;
    int last;
    Resetn = 1'b0; Start = 1'b0; Stop = 1'b0; Rate = 4'd1; Q = 8'd0;
    repeat (3) tick();
    check("reset once outputs", int'({duty0, st0, busy0, done0}), 0);
    check("reset loop outputs", int'({duty1, st1, busy1, done1}), 0);
    Resetn = 1'b1;
    tick();

    // ---- full one-shot sequence, Rate=1 ----
    Start = 1'b1; tick(); Start = 1'b0;
    check("rise entered state", int'(st0), 1);
    check("rise entered busy", int'(busy0), 1);
    c = 0; k = 0; lastc = 0; last = duty0;
    while (st0 != 2'd2 && c < 9000) begin
      tick(); c++;
      if (int'(duty0) != last) begin
        if (k < 31) check("rise value", int'(duty0), tbl[k + 1]);
        if (k > 0) check("rise step interval", c - lastc, 256);
        lastc = c; k++; last = duty0;
      end
    end
    check("reached hold", int'(st0), 2);
    check("rise step count", k, 31);
    check("hold duty", int'(duty0), 255);
    n = 1;
    while (st0 == 2'd2 && n < 2000) begin
      tick();
      if (st0 == 2'd2) n++;
    end
    check("hold cycles", n, 512);
    check("fall entered state", int'(st0), 3);
    check("fall entry duty", int'(duty0), 255);
    c = 0; k = 0; last = duty0;
    while (!done0 && c < 9000) begin
      tick(); c++;
      if (int'(duty0) != last) begin
        if (k < 31) check("fall value", int'(duty0), tbl[30 - k]);
        k++; last = duty0;
      end
    end
    check("done pulse", int'(done0), 1);
    check("fall step count", k, 31);
    check("once idle at done", int'(st0), 0);
    check("once duty at done", int'(duty0), 0);
    check("loop back to rise", int'(st1), 1);
    check("loop no done", int'(done1), 0);
    tick();
    check("done one cycle", int'(done0), 0);

    // ---- Rate=0 vs Rate=1 traces ----
    Stop = 1'b1; tick(); Stop = 1'b0;
    Rate = 4'd0; Q = 8'd0; Start = 1'b1; tick(); Start = 1'b0;
    for (int i = 0; i < 2048; i++) begin tick(); trace_a[i] = int'(duty0); end
    Stop = 1'b1; tick(); Stop = 1'b0;
    Rate = 4'd1; Q = 8'd0; Start = 1'b1; tick(); Start = 1'b0;
    for (int i = 0; i < 2048; i++) begin tick(); trace_b[i] = int'(duty0); end
    mism = 0;
    for (int i = 0; i < 2048; i++) if (trace_a[i] != trace_b[i]) mism++;
    check("rate0 vs rate1 trace mismatches", mism, 0);
    check("trace before first wrap", trace_b[253], 0);
    check("trace first step", trace_b[254], 1);
    check("trace after 8 steps", trace_b[2047], 17);

    // ---- Stop mid-RISE at Q=100 ----
    c = 0;
    while (Q != 8'd100 && c < 300) begin tick(); c++; end
    check("pre-stop Q", int'(Q), 100);
    check("pre-stop duty nonzero", int'(duty0 != 8'd0), 1);
    Stop = 1'b1; tick();
    check("stop duty", int'(duty0), 0);
    check("stop state", int'(st0), 0);
    check("stop no done", int'(done0), 0);

    // ---- Start and Stop together in IDLE ----
    Start = 1'b1;
    repeat (4) tick();
    check("start+stop stays idle", int'(st0), 0);
    check("start+stop not busy", int'(busy1), 0);

    // ---- Rate=4, Start held high (ignored after entry) ----
    Rate = 4'd4; Stop = 1'b0; tick();
    check("rate4 rise entered", int'(st0), 1);
    c = 0; k = 0; lastc = 0; last = duty0;
    while (k < 4 && c < 6000) begin
      tick(); c++;
      if (int'(duty0) != last) begin
        if (k > 0) check("rate4 hold per value", c - lastc, 1024);
        lastc = c; k++; last = duty0;
      end
    end
    check("rate4 step count", k, 4);
    Start = 1'b0;
    // Two wraps at Rate=4 leave the counter at 2; switching to Rate=1 must
    // step on the third wrap.
    repeat (600) tick();
    c = c + 600;
    Rate = 4'd1;
    while (int'(duty0) == last && c - lastc < 1200) begin tick(); c++; end
    check("rate drop step gap", c - lastc, 768);
    Stop = 1'b1; tick(); Stop = 1'b0;

    // ---- asynchronous reset during HOLD ----
    Rate = 4'd1; Start = 1'b1; tick(); Start = 1'b0;
    c = 0;
    while (st0 != 2'd2 && c < 9000) begin tick(); c++; end
    check("reached hold before reset", int'(st0), 2);
    repeat (100) tick();
    #2;
    Resetn = 1'b0;
    #1;
    check("async reset once outputs", int'({duty0, st0, busy0, done0}), 0);
    check("async reset loop outputs", int'({duty1, st1, busy1, done1}), 0);
    repeat (3) tick();
    Resetn = 1'b1;
    repeat (600) tick();
    check("after reset awaits start once", int'(st0), 0);
    check("after reset awaits start loop", int'(st1), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire

// File: doc/fade_ramp_ctrl.md
FADE_RAMP_CTRL -- requirements
Module: fade_ramp_ctrl

Interface
REQ-001 The block SHALL have parameter HOLD_PERIODS, default 64, giving the number of PWM periods held at full brightness.
REQ-002 The block SHALL have parameter LOOP_EN, default 1, where 1 restarts RISE after FALL and 0 returns to IDLE.
REQ-003 The block SHALL have the port Clock, input, 1 bit, the system clock; all state updates on its rising edge.
REQ-004 The block SHALL have the port Resetn, input, 1 bit, an asynchronous active-low reset.
REQ-005 The block SHALL have the port Start, input, 1 bit, a level request that begins a fade sequence from IDLE.
REQ-006 The block SHALL have the port Stop, input, 1 bit, a level request that aborts to IDLE.
REQ-007 The block SHALL have the port Rate, input, 4 bits, giving the PWM periods per LUT step, with 0 treated as 1.
REQ-008 The block SHALL have the port Q, input, 8 bits, carrying the downstream PWM counter value.
REQ-009 The block SHALL have the port Duty, output, 8 bits, a registered duty value that feeds the downstream PWM.
REQ-010 The block SHALL have the port State, output, 2 bits, giving the current state (IDLE=0, RISE=1, HOLD=2, FALL=3).
REQ-011 The block SHALL have the port Busy, output, 1 bit, which is high whenever State != IDLE.
REQ-012 The block SHALL have the port Done, output, 1 bit, a one-cycle pulse when a non-looping sequence ends.

Function
REQ-013 Wrap SHALL be defined as (Q == 8'd255) in the current cycle; every Duty change except Stop/reset SHALL occur only on a Wrap edge, so the new value is used from Q=0.
REQ-014 A 5-bit index Idx SHALL address a 32-entry brightness LUT: LUT[0]=0, LUT[31]=255, monotonic non-decreasing.
REQ-015 A 4-bit period counter PerCnt SHALL increment on each Wrap; a step SHALL occur on the Wrap at which PerCnt+1 equals max(Rate,1), and PerCnt SHALL clear on that step.
REQ-016 In IDLE, with Start=1 and Stop=0, the block SHALL enter RISE on the next edge with Idx=0, PerCnt=0, and Duty=LUT[0].
REQ-017 In RISE, each step SHALL set Idx to Idx+1 and Duty to LUT[Idx+1]; the step that reaches Idx=31 SHALL enter HOLD.
REQ-018 In HOLD, PerCnt SHALL count Wraps, and after HOLD_PERIODS Wraps the block SHALL enter FALL with Duty unchanged.
REQ-019 In FALL, each step SHALL set Idx to Idx-1 and Duty to LUT[Idx-1]; the step that reaches Idx=0 SHALL enter RISE if LOOP_EN=1, else enter IDLE and pulse Done.
REQ-020 Stop=1 in any state SHALL, on the next edge, force IDLE, Duty=0, Idx=0, and PerCnt=0, without waiting for Wrap and without a Done pulse.
REQ-021 When Start and Stop are both high, Stop SHALL win.
REQ-022 Start SHALL be ignored outside IDLE.
REQ-023 A change of Rate mid-sequence SHALL take effect at the next step comparison, and if PerCnt already meets or exceeds the new divisor, the step SHALL occur on the next Wrap.
REQ-024 Idx SHALL never wrap: there SHALL be no increment past 31 and no decrement below 0.

Reset
REQ-025 While Resetn=0, the block SHALL asynchronously hold State=IDLE, Duty=0, Idx=0, PerCnt=0, Busy=0, and Done=0.
REQ-026 When reset is asserted mid-sequence, the block SHALL abandon the sequence, and after release SHALL await a new Start.

Structure
REQ-027 The package fade_pkg SHALL hold the state encoding, LUT_DEPTH=32, and the LUT contents constant.
REQ-028 The LUT SHALL be a combinational sub-module fade_lut with a 5-bit address and 8-bit data; the remaining logic SHALL be a single FSM plus counters in fade_ramp_ctrl.

Verification
REQ-029 The bench SHALL cover: Rate=1, HOLD_PERIODS=2, LOOP_EN=0, Start pulsed, with Q from a free-running 8-bit counter -> Duty steps LUT[0..31] once per 256 cycles, HOLD lasts 512 cycles, then LUT[31..0], followed by a Done pulse and IDLE.
REQ-030 The bench SHALL cover: Rate=0 versus Rate=1 -> identical Duty traces.
REQ-031 The bench SHALL cover: Rate=4 -> each Duty value held for exactly 1024 cycles during RISE.
REQ-032 The bench SHALL cover: Stop asserted mid-RISE at Q=100 -> next edge gives Duty=0 and State=0, with Done low.
REQ-033 The bench SHALL cover: Start and Stop high together in IDLE -> the block remains in IDLE; and Resetn low during HOLD -> all outputs 0 immediately, without waiting for a clock edge.
REQ-034 The bench SHALL cover: LOOP_EN=1 -> after Idx reaches 0 in FALL, State returns to RISE with no Done pulse; and Duty changes are checked to occur only at Q 255->0 transitions.
